// File: rtl/span_walker.sv
// span_walker: walks one horizontal span per lineStart, interpolating Z/RGB with saturation and writing depth-passing pixels as RGB565.
// Optional depth test enabled by defining SPAN_ZTEST_EN; otherwise every pixel passes.
module span_walker #(
  parameter int XW = 10
) (
  input  logic          clk100,
  input  logic          reset_n,
  input  logic [XW-1:0] X1,
  input  logic [XW-1:0] X2,
  input  logic [25:0]   Z1,
  input  logic [26:0]   NZ,
  input  logic [21:0]   R1,
  input  logic [22:0]   NR,
  input  logic [21:0]   G1,
  input  logic [22:0]   NG,
  input  logic [17:0]   B1,
  input  logic [18:0]   NB,
  input  logic          lineStart,
  output logic          lineDone,
  input  logic          nextFrame,
  output logic [XW-1:0] zrd_addr,
  input  logic [25:0]   zrd_data,
  output logic          zwr_en,
  output logic [XW-1:0] zwr_addr,
  output logic [25:0]   zwr_data,
  output logic          pix_wr_en,
  output logic [XW-1:0] pix_addr,
  output logic [15:0]   pix_data
);
  localparam int PIPE_LAT = 2;
  typedef enum logic [1:0] {IDLE, WALK, DRAIN} state_t;
  state_t st;
  logic [XW-1:0] x, cnt, n;
  logic neg;
  logic [1:0] dcnt;
  logic [25:0] z, z_nx, s1_z;
  logic [26:0] nz, zs;
  logic [21:0] r, g, r_nx, g_nx, s1_r, s1_g;
  logic [22:0] nr, ng, rs, gs;
  logic [17:0] b, b_nx, s1_b;
  logic [18:0] nb, bs;
  logic [XW-1:0] s1_x;
  logic s1_v, pass;
  // Sum one bit wider than the value; a set MSB means over- or underflow depending on step sign.
  assign zs = {1'b0, z} + nz;
  assign rs = {1'b0, r} + nr;
  assign gs = {1'b0, g} + ng;
  assign bs = {1'b0, b} + nb;
  assign z_nx = zs[26] ? {26{~nz[26]}} : zs[25:0];
  assign r_nx = rs[22] ? {22{~nr[22]}} : rs[21:0];
  assign g_nx = gs[22] ? {22{~ng[22]}} : gs[21:0];
  assign b_nx = bs[18] ? {18{~nb[18]}} : bs[17:0];
  assign n = X2 > X1 ? X2 - X1 : X1 - X2;
`ifdef SPAN_ZTEST_EN
  assign zrd_addr = x;
  assign pass = s1_z < zrd_data;
`else
  logic unused_zrd;
  assign unused_zrd = ^zrd_data;
  assign zrd_addr = '0;
  assign pass = 1'b1;
`endif
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      lineDone <= 1'b1;
      x <= '0;
      cnt <= '0;
      neg <= 1'b0;
      dcnt <= '0;
      z <= '0;
      r <= '0;
      g <= '0;
      b <= '0;
      nz <= '0;
      nr <= '0;
      ng <= '0;
      nb <= '0;
      s1_v <= 1'b0;
      s1_x <= '0;
      s1_z <= '0;
      s1_r <= '0;
      s1_g <= '0;
      s1_b <= '0;
      zwr_en <= 1'b0;
      pix_wr_en <= 1'b0;
      zwr_addr <= '0;
      zwr_data <= '0;
      pix_addr <= '0;
      pix_data <= '0;
    end else if (nextFrame) begin
      st <= IDLE;
      lineDone <= 1'b1;
      s1_v <= 1'b0;
      zwr_en <= 1'b0;
      pix_wr_en <= 1'b0;
    end else begin
      s1_v <= st == WALK;
      s1_x <= x;
      s1_z <= z;
      s1_r <= r;
      s1_g <= g;
      s1_b <= b;
      zwr_en <= s1_v && pass;
      pix_wr_en <= s1_v && pass;
      zwr_addr <= s1_x;
      pix_addr <= s1_x;
      zwr_data <= s1_z;
      pix_data <= {s1_r[21:17], s1_g[21:16], s1_b[17:13]};
      case (st)
        IDLE: if (lineStart) begin
          x <= X1;
          z <= Z1;
          r <= R1;
          g <= G1;
          b <= B1;
          nz <= NZ;
          nr <= NR;
          ng <= NG;
          nb <= NB;
          neg <= !(X2 > X1);
          cnt <= n;
          dcnt <= 2'(PIPE_LAT - 1);
          lineDone <= 1'b0;
          st <= n != '0 ? WALK : DRAIN;
        end
        WALK: begin
          x <= neg ? x - 1'b1 : x + 1'b1;
          z <= z_nx;
          r <= r_nx;
          g <= g_nx;
          b <= b_nx;
          cnt <= cnt - 1'b1;
          st <= cnt == 1 ? DRAIN : WALK;
        end
        DRAIN: begin
          dcnt <= dcnt - 1'b1;
          lineDone <= dcnt == 0;
          st <= dcnt == 0 ? IDLE : DRAIN;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_span_walker.sv
// tb_span_walker: directed and random spans checked against a per-pixel arithmetic model with a behavioural Z RAM.
module tb_span_walker;
`ifdef SPAN_ZTEST_EN
  localparam bit ZT = 1'b1;
`else
  localparam bit ZT = 1'b0;
`endif
  logic clk100 = 0, reset_n = 0;
  logic [9:0] X1 = 0, X2 = 0;
  logic [25:0] Z1 = 0;
  logic [26:0] NZ = 0;
  logic [21:0] R1 = 0, G1 = 0;
  logic [22:0] NR = 0, NG = 0;
  logic [17:0] B1 = 0;
  logic [18:0] NB = 0;
  logic lineStart = 0, nextFrame = 0, lineDone, zwr_en, pix_wr_en;
  logic [9:0] zrd_addr, zwr_addr, pix_addr;
  logic [25:0] zrd_data, zwr_data;
  logic [15:0] pix_data;
  logic [25:0] zmem [1024];
  logic fill = 0, poke = 0;
  logic [9:0] poke_a = 0;
  logic [25:0] poke_v = 0;
  int errors = 0, checks = 0;

  span_walker dut (.clk100(clk100), .reset_n(reset_n), .X1(X1), .X2(X2), .Z1(Z1), .NZ(NZ),
    .R1(R1), .NR(NR), .G1(G1), .NG(NG), .B1(B1), .NB(NB), .lineStart(lineStart),
    .lineDone(lineDone), .nextFrame(nextFrame), .zrd_addr(zrd_addr), .zrd_data(zrd_data),
    .zwr_en(zwr_en), .zwr_addr(zwr_addr), .zwr_data(zwr_data), .pix_wr_en(pix_wr_en),
    .pix_addr(pix_addr), .pix_data(pix_data));

  always #5 clk100 = ~clk100;

  always @(posedge clk100) begin
    if (fill) for (int i = 0; i < 1024; i++) zmem[i] <= '1;
    else if (poke) zmem[poke_a] <= poke_v;
    else if (zwr_en) zmem[zwr_addr] <= zwr_data;
    zrd_data <= zmem[zrd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic longint sat(input longint v, input longint st, input int w);
    longint s = v + st;
    longint mx = (longint'(1) << w) - 1;
    return s > mx ? mx : (s < 0 ? 0 : s);
  endfunction

  task automatic fill_ones();
    @(negedge clk100) fill = 1;
    @(negedge clk100) fill = 0;
  endtask

  task automatic poke_z(input int a, input logic [25:0] v);
    @(negedge clk100) begin poke = 1; poke_a = 10'(a); poke_v = v; end
    @(negedge clk100) poke = 0;
  endtask

  task automatic set_span(input int x1, input int x2, input longint z1, input longint nz,
                          input longint r1, input longint nr, input longint g1, input longint ng,
                          input longint b1, input longint nb);
    X1 = 10'(x1); X2 = 10'(x2); Z1 = 26'(z1); NZ = 27'(nz);
    R1 = 22'(r1); NR = 23'(nr); G1 = 22'(g1); NG = 23'(ng); B1 = 18'(b1); NB = 19'(nb);
  endtask

  // ab: cycle in which nextFrame is asserted; rs: cycle of a spurious lineStart (0 = none)
  task automatic run_span(input int ab, input int rs, input string nm);
    int ea[64], n, dir, k;
    longint ez[64], zv, rv, gv, bv;
    logic [15:0] ep[64];
    bit ps[64], abort, w;
    int x1 = int'(X1), x2 = int'(X2);
    n = x2 > x1 ? x2 - x1 : x1 - x2;
    dir = x2 > x1 ? 1 : -1;
    zv = longint'(Z1); rv = longint'(R1); gv = longint'(G1); bv = longint'(B1);
    for (int i = 0; i < n; i++) begin
      logic [21:0] r22 = 22'(rv), g22 = 22'(gv);
      logic [17:0] b18 = 18'(bv);
      ea[i] = x1 + dir * i;
      ez[i] = zv;
      ep[i] = {r22[21:17], g22[21:16], b18[17:13]};
      ps[i] = ZT ? (zv < longint'(zmem[ea[i]])) : 1'b1;
      zv = sat(zv, longint'($signed(NZ)), 26);
      rv = sat(rv, longint'($signed(NR)), 22);
      gv = sat(gv, longint'($signed(NG)), 22);
      bv = sat(bv, longint'($signed(NB)), 18);
    end
    @(negedge clk100) lineStart = 1;
    @(negedge clk100) lineStart = 0;
    for (int c = 1; c <= n + 4; c++) begin
      abort = ab > 0 && c > ab;
      k = c - 3;
      w = !abort && k >= 0 && k < n && ps[k];
      chk({nm, ".lineDone"}, 32'(lineDone), 32'(abort || c >= n + 3));
      chk({nm, ".zwr_en"}, 32'(zwr_en), 32'(w));
      chk({nm, ".pix_wr_en"}, 32'(pix_wr_en), 32'(w));
      if (w) begin
        chk({nm, ".pix_addr"}, 32'(pix_addr), 32'(ea[k]));
        chk({nm, ".zwr_addr"}, 32'(zwr_addr), 32'(ea[k]));
        chk({nm, ".zwr_data"}, 32'(zwr_data), 32'(ez[k]));
        chk({nm, ".pix_data"}, 32'(pix_data), 32'(ep[k]));
      end
      if (!abort && c - 1 < n) chk({nm, ".zrd_addr"}, 32'(zrd_addr), ZT ? 32'(ea[c-1]) : 32'd0);
      if (c == ab) nextFrame = 1;
      if (c == rs) begin
        lineStart = 1;
        set_span(300, 310, 1, 1, 0, 0, 0, 0, 0, 0);
      end
      @(negedge clk100);
      nextFrame = 0;
      lineStart = 0;
    end
  endtask

  initial begin
    #12;
    chk("rst.lineDone", 32'(lineDone), 32'd1);
    chk("rst.zwr_en", 32'(zwr_en), 32'd0);
    chk("rst.pix_wr_en", 32'(pix_wr_en), 32'd0);
    chk("rst.pix_addr", 32'(pix_addr), 32'd0);
    chk("rst.pix_data", 32'(pix_data), 32'd0);
    chk("rst.zrd_addr", 32'(zrd_addr), 32'd0);
    @(negedge clk100) reset_n = 1;
    fill_ones();
    set_span(10, 14, 100, 5, 22'h123456, 23'h1000, 22'h0ABCDE, -23'sh800, 18'h2ABCD, 19'h400);
    run_span(0, 0, "fwd");
    set_span(20, 17, 500, -7, 22'h3F0000, -23'sh40000, 22'h100000, 23'h30000, 18'h00F00, 19'h4000);
    run_span(0, 0, "rev");
    fill_ones();
    poke_z(11, 26'd105);
    set_span(10, 14, 100, 5, 0, 0, 0, 0, 0, 0);
    run_span(0, 0, "zeq");
    fill_ones();
    set_span(40, 44, 7, 1, 22'h3FFF00, 23'h200, 22'h3FFFFF, 23'h1, 18'h100, -19'sh200);
    run_span(0, 0, "sat");
    set_span(50, 54, 9, 1, 22'h200000, 1, 0, 0, 0, 0);
    run_span(2, 0, "abort");
    set_span(60, 63, 3, 2, 0, 23'h10000, 0, 0, 0, 19'h800);
    run_span(0, 2, "relaunch");
    set_span(70, 70, 3, 1, 0, 0, 0, 0, 0, 0);
    run_span(0, 0, "empty");
    for (int t = 0; t < 10; t++) begin
      int x1 = $urandom_range(20, 619);
      int x2 = x1 + $urandom_range(0, 20) - 10;
      for (int a = (x1 < x2 ? x1 : x2); a <= (x1 < x2 ? x2 : x1); a++)
        poke_z(a, 26'($urandom));
      set_span(x1, x2, $urandom & 26'h3FFFFFF, longint'($signed(27'($urandom))) >>> $urandom_range(0, 24),
               $urandom & 22'h3FFFFF, longint'($signed(23'($urandom))) >>> $urandom_range(0, 20),
               $urandom & 22'h3FFFFF, longint'($signed(23'($urandom))) >>> $urandom_range(0, 20),
               $urandom & 18'h3FFFF, longint'($signed(19'($urandom))) >>> $urandom_range(0, 16));
      run_span(0, 0, "rand");
    end
    fill_ones();
    set_span(100, 110, 5, 1, 22'h3FFFFF, 0, 22'h3FFFFF, 0, 18'h3FFFF, 0);
    @(negedge clk100) lineStart = 1;
    @(negedge clk100) lineStart = 0;
    repeat (3) @(negedge clk100);
    chk("mid.pix_wr_en", 32'(pix_wr_en), 32'd1);
    #1 reset_n = 0;
    #1;
    chk("arst.lineDone", 32'(lineDone), 32'd1);
    chk("arst.zwr_en", 32'(zwr_en), 32'd0);
    chk("arst.pix_wr_en", 32'(pix_wr_en), 32'd0);
    chk("arst.pix_addr", 32'(pix_addr), 32'd0);
    chk("arst.zwr_addr", 32'(zwr_addr), 32'd0);
    chk("arst.zwr_data", 32'(zwr_data), 32'd0);
    chk("arst.pix_data", 32'(pix_data), 32'd0);
    chk("arst.zrd_addr", 32'(zrd_addr), 32'd0);
    @(negedge clk100) reset_n = 1;
    repeat (2) @(negedge clk100);
    chk("post.lineDone", 32'(lineDone), 32'd1);
    chk("post.pix_wr_en", 32'(pix_wr_en), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
